// File: rtl/sys_job_pkg.sv
// Shared definitions for the systolic job controller.
//   - FSM state encoding (LOAD, FEED, COLLECT, OUT)
//   - idx_width(): width of a row/column index for an N x N matrix
//   - wdog_limit(): COLLECT watchdog budget in cycles (4 * N)
package sys_job_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StLoad    = 2'd0;
    localparam state_t StFeed    = 2'd1;
    localparam state_t StCollect = 2'd2;
    localparam state_t StOut     = 2'd3;

    localparam int unsigned WDOG_MULT = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // WDOG_LIMIT for a given matrix dimension.
    function automatic int unsigned wdog_limit(input int unsigned n);
        return WDOG_MULT * n;
    endfunction

endpackage

// File: rtl/sys_mat_buf.sv
// N_SIZE x N_SIZE register store of WIDTH-bit elements.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears all elements)
//   wr_en        write one full row
//   wr_row       row index written
//   wr_data      row data, element j at [(j+1)*WIDTH-1 -: WIDTH]
//   rd_row       row index read on rd_row_data (combinational)
//   rd_row_data  row rd_row, element j packed as above
//   rd_col       column index read on rd_col_data (combinational)
//   rd_col_data  column rd_col, element i = mem[i][rd_col]
module sys_mat_buf
    import sys_job_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned N_SIZE = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [idx_width(N_SIZE)-1:0]    wr_row,
    input  logic [N_SIZE*WIDTH-1:0]         wr_data,
    input  logic [idx_width(N_SIZE)-1:0]    rd_row,
    output logic [N_SIZE*WIDTH-1:0]         rd_row_data,
    input  logic [idx_width(N_SIZE)-1:0]    rd_col,
    output logic [N_SIZE*WIDTH-1:0]         rd_col_data
);

    localparam int unsigned IW = idx_width(N_SIZE);

    logic [WIDTH-1:0] mem_q [N_SIZE][N_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SIZE; i++) begin
                for (int j = 0; j < N_SIZE; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int i = 0; i < N_SIZE; i++) begin
                if (wr_row == IW'(i)) begin
                    for (int j = 0; j < N_SIZE; j++) begin
                        mem_q[i][j] <= wr_data[j*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Explicit compare muxes keep out-of-range index codes (N_SIZE not a power of 2) benign.
    always_comb begin
        rd_row_data = '0;
        rd_col_data = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            for (int j = 0; j < N_SIZE; j++) begin
                if (rd_row == IW'(i)) begin
                    rd_row_data[j*WIDTH +: WIDTH] = mem_q[i][j];
                end
                if (rd_col == IW'(j)) begin
                    rd_col_data[i*WIDTH +: WIDTH] = mem_q[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_job_ctrl.sv
// Job sequencer in front of an N_SIZE x N_SIZE output-stationary systolic multiplier.
// Buffers A and B (row-major load), feeds A columns / B rows for N_SIZE cycles, captures
// the N_SIZE result rows and replays them downstream with full valid/ready flow control.
//
// Optional: define SYS_JOB_CTRL_WDOG_EN to enable the COLLECT watchdog (sticky err).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ld_valid/ld_ready       load beat handshake
//   ld_sel                  0 = A row, 1 = B row
//   ld_data                 one matrix row, element j at [(j+1)*DATAWIDTH-1 -: DATAWIDTH]
//   res_valid/res_ready     result row handshake
//   res_data                C row, elements of 2*DATAWIDTH
//   res_last                high with row N_SIZE-1
//   busy                    high in FEED, COLLECT, OUT
//   err                     sticky watchdog error (0 without the watchdog)
//   arr_rst_n               registered active-low array reset
//   arr_valid_in, arr_a, arr_b   array feed (A column k, B row k)
//   arr_valid_out, arr_c         array result rows
module systolic_job_ctrl
    import sys_job_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned N_SIZE    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic                          ld_sel,
    input  logic [N_SIZE*DATAWIDTH-1:0]   ld_data,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [N_SIZE*2*DATAWIDTH-1:0] res_data,
    output logic                          res_last,
    output logic                          busy,
    output logic                          err,
    output logic                          arr_rst_n,
    output logic                          arr_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]   arr_a,
    output logic [N_SIZE*DATAWIDTH-1:0]   arr_b,
    input  logic                          arr_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0] arr_c
);

    localparam int unsigned   IW      = idx_width(N_SIZE);
    localparam int unsigned   RW      = N_SIZE * DATAWIDTH;
    localparam int unsigned   CRW     = N_SIZE * 2 * DATAWIDTH;
    localparam logic [IW-1:0] LastIdx = IW'(N_SIZE - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] a_cnt_q, a_cnt_d;
    logic [IW-1:0] b_cnt_q, b_cnt_d;
    logic          a_full_q, a_full_d;
    logic          b_full_q, b_full_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] r_q, r_d;
    logic          arr_rst_n_q, arr_rst_n_d;

    logic           in_feed, in_collect, in_out;
    logic           ld_fire, a_wr, b_wr, c_wr, res_fire;
    logic [RW-1:0]  a_col, b_row;
    logic [CRW-1:0] c_row;
    logic [RW-1:0]  unused_a_row, unused_b_col;
    logic [CRW-1:0] unused_c_col;

    assign in_feed    = (state_q == StFeed);
    assign in_collect = (state_q == StCollect);
    assign in_out     = (state_q == StOut);

    // Loading is allowed everywhere except FEED, where the buffers are being read.
    assign ld_ready = !in_feed && !(ld_sel ? b_full_q : a_full_q);
    assign ld_fire  = ld_valid && ld_ready;
    assign a_wr     = ld_fire && !ld_sel;
    assign b_wr     = ld_fire && ld_sel;
    assign c_wr     = in_collect && arr_valid_out;

    assign res_valid = in_out;
    assign res_fire  = res_valid && res_ready;
    assign res_last  = in_out && (r_q == LastIdx);
    assign res_data  = in_out ? c_row : '0;

    assign busy         = (state_q != StLoad);
    assign arr_rst_n    = arr_rst_n_q;
    assign arr_valid_in = in_feed;
    assign arr_a        = in_feed ? a_col : '0;
    assign arr_b        = in_feed ? b_row : '0;

    sys_mat_buf #(
        .WIDTH  (DATAWIDTH),
        .N_SIZE (N_SIZE)
    ) u_a_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (a_wr),
        .wr_row      (a_cnt_q),
        .wr_data     (ld_data),
        .rd_row      ('0),
        .rd_row_data (unused_a_row),
        .rd_col      (k_q),
        .rd_col_data (a_col)
    );

    sys_mat_buf #(
        .WIDTH  (DATAWIDTH),
        .N_SIZE (N_SIZE)
    ) u_b_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (b_wr),
        .wr_row      (b_cnt_q),
        .wr_data     (ld_data),
        .rd_row      (k_q),
        .rd_row_data (b_row),
        .rd_col      ('0),
        .rd_col_data (unused_b_col)
    );

    // r_q indexes the capture row in COLLECT and the replay row in OUT.
    sys_mat_buf #(
        .WIDTH  (2 * DATAWIDTH),
        .N_SIZE (N_SIZE)
    ) u_c_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (c_wr),
        .wr_row      (r_q),
        .wr_data     (arr_c),
        .rd_row      (r_q),
        .rd_row_data (c_row),
        .rd_col      ('0),
        .rd_col_data (unused_c_col)
    );

`ifdef SYS_JOB_CTRL_WDOG_EN
    localparam int unsigned   WDOG_LIMIT = wdog_limit(N_SIZE);
    localparam int unsigned   WW         = $clog2(WDOG_LIMIT);
    localparam logic [WW-1:0] WdogLast   = WW'(WDOG_LIMIT - 1);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          wdog_expired;

    // Counts COLLECT cycles; zero everywhere else so each COLLECT entry starts fresh.
    assign wdog_d       = in_collect ? wdog_q + 1'b1 : '0;
    assign wdog_expired = in_collect && (wdog_q == WdogLast);
    assign err          = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`else
    logic wdog_expired;
    logic err_d;

    assign wdog_expired = 1'b0;
    assign err          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        a_full_d    = a_full_q;
        b_full_d    = b_full_q;
        k_d         = k_q;
        r_d         = r_q;
        arr_rst_n_d = arr_rst_n_q;
        err_d       = err;

        if (a_wr) begin
            if (a_cnt_q == LastIdx) begin
                a_cnt_d  = '0;
                a_full_d = 1'b1;
            end else begin
                a_cnt_d = a_cnt_q + 1'b1;
            end
        end
        if (b_wr) begin
            if (b_cnt_q == LastIdx) begin
                b_cnt_d  = '0;
                b_full_d = 1'b1;
            end else begin
                b_cnt_d = b_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            StLoad: begin
                if (a_full_q && b_full_q) begin
                    state_d     = StFeed;
                    k_d         = '0;
                    arr_rst_n_d = 1'b1;
                end
            end
            StFeed: begin
                if (k_q == LastIdx) begin
                    state_d  = StCollect;
                    k_d      = '0;
                    r_d      = '0;
                    a_full_d = 1'b0;
                    b_full_d = 1'b0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StCollect: begin
                // A final row landing on the last watchdog cycle still completes the job.
                if (arr_valid_out && (r_q == LastIdx)) begin
                    state_d     = StOut;
                    r_d         = '0;
                    arr_rst_n_d = 1'b0;
                end else if (wdog_expired) begin
                    state_d     = StLoad;
                    r_d         = '0;
                    arr_rst_n_d = 1'b0;
                    err_d       = 1'b1;
                end else if (arr_valid_out) begin
                    r_d = r_q + 1'b1;
                end
            end
            StOut: begin
                if (res_fire) begin
                    if (r_q == LastIdx) begin
                        r_d = '0;
                        if (a_full_q && b_full_q) begin
                            state_d     = StFeed;
                            k_d         = '0;
                            arr_rst_n_d = 1'b1;
                        end else begin
                            state_d = StLoad;
                        end
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            a_full_q    <= 1'b0;
            b_full_q    <= 1'b0;
            k_q         <= '0;
            r_q         <= '0;
            arr_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            a_full_q    <= a_full_d;
            b_full_q    <= b_full_d;
            k_q         <= k_d;
            r_q         <= r_d;
            arr_rst_n_q <= arr_rst_n_d;
        end
    end

`ifndef SYS_JOB_CTRL_WDOG_EN
    logic unused_err_d;
    assign unused_err_d = err_d;
`endif

endmodule

// File: tb/tb_systolic_job_ctrl.sv
`timescale 1ns/1ps
module tb_systolic_job_ctrl;

    localparam int N   = 2;
    localparam int DW  = 16;
    localparam int CW  = 32;
    localparam int LAT = 3;

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic            ld_sel = 1'b0;
    logic [N*DW-1:0] ld_data = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [N*CW-1:0] res_data;
    logic            res_last;
    logic            busy;
    logic            err;
    logic            arr_rst_n;
    logic            arr_valid_in;
    logic [N*DW-1:0] arr_a;
    logic [N*DW-1:0] arr_b;
    logic            arr_valid_out = 1'b0;
    logic [N*CW-1:0] arr_c = '0;

    int checks = 0;
    int failures = 0;

    logic [N*CW-1:0] got_data[$];
    bit              got_last[$];

    always #5 clk = ~clk;

    systolic_job_ctrl #(
        .DATAWIDTH (DW),
        .N_SIZE    (N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_sel        (ld_sel),
        .ld_data       (ld_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_last      (res_last),
        .busy          (busy),
        .err           (err),
        .arr_rst_n     (arr_rst_n),
        .arr_valid_in  (arr_valid_in),
        .arr_a         (arr_a),
        .arr_b         (arr_b),
        .arr_valid_out (arr_valid_out),
        .arr_c         (arr_c)
    );

    // Stand-in for the systolic array: accumulates outer products while fed, then emits
    // the N result rows LAT cycles later. Cleared only through arr_rst_n.
    logic [CW-1:0] acc [N][N];
    int            fed = 0;
    int            ph = 0;
    bit            block_out = 1'b0;

    function automatic logic [N*CW-1:0] acc_row(input int r);
        logic [N*CW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*CW +: CW] = acc[r][j];
        return v;
    endfunction

    always @(posedge clk) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
            fed           <= 0;
            ph            <= 0;
            arr_valid_out <= 1'b0;
            arr_c         <= '0;
        end else begin
            arr_valid_out <= 1'b0;
            if (arr_valid_in) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= acc[i][j] + CW'(arr_a[i*DW +: DW]) * CW'(arr_b[j*DW +: DW]);
                fed <= fed + 1;
                if (fed == N - 1) ph <= 1;
            end
            if (ph != 0) begin
                ph <= (ph == LAT + N - 1) ? 0 : ph + 1;
                if (ph >= LAT) begin
                    arr_valid_out <= !block_out;
                    arr_c         <= acc_row(ph - LAT);
                end
            end
        end
    end

    // Reference: C = A x B modulo 2^CW, one packed row.
    function automatic logic [N*CW-1:0] model_row(input mat_t a, input mat_t b, input int r);
        logic [N*CW-1:0] row;
        longint unsigned s;
        row = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s = s + 64'(a[r][k]) * 64'(b[k][j]);
            row[j*CW +: CW] = CW'(s);
        end
        return row;
    endfunction

    function automatic logic [N*DW-1:0] col_of(input mat_t m, input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m[i][k];
        return v;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m[i][j] = 16'($urandom);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap(input int max_gap);
        repeat ($urandom_range(max_gap)) tick();
    endtask

    task automatic send_beat(input logic sel, input logic [N*DW-1:0] data, output bit ok);
        bit acc_now;
        ok       = 1'b0;
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_data  = data;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            acc_now = ld_ready;
            tick();
            if (acc_now) begin
                ok = 1'b1;
                break;
            end
        end
        ld_valid = 1'b0;
    endtask

    // order 0: A rows then B rows; order 1: B0,A0,B1,A1,...
    task automatic load_job(input mat_t a, input mat_t b, input int order, input int max_gap,
                            output bit ok);
        bit bok;
        bit sel;
        int row;
        ok = 1'b1;
        for (int s = 0; s < 2 * N; s++) begin
            sel = (order == 0) ? (s >= N) : (s % 2 == 0);
            row = (order == 0) ? (s % N) : (s / 2);
            idle_gap(max_gap);
            send_beat(sel, sel ? b[row] : a[row], bok);
            ok = ok && bok;
        end
    endtask

    // Returns at the negedge of the first FEED cycle.
    task automatic wait_feed(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (arr_valid_in) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic get_rows(input int n, input int stall_pct, output bit ok);
        got_data.delete();
        got_last.delete();
        for (int c = 0; c < 500 && got_data.size() < n; c++) begin
            res_ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (res_valid && res_ready) begin
                got_data.push_back(res_data);
                got_last.push_back(res_last);
            end
            tick();
        end
        res_ready = 1'b0;
        ok = (got_data.size() == n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ld_ready, res_valid, res_last, busy, err, arr_rst_n, arr_valid_in} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=1000000",
                     {ld_ready, res_valid, res_last, busy, err, arr_rst_n, arr_valid_in});
        end
        checks++;
        if (arr_a !== '0 || arr_b !== '0) begin
            failures++;
            $display("FAIL reset_arr_ab got=%h/%h exp=0/0", arr_a, arr_b);
        end
        checks++;
        if (res_data !== '0) begin
            failures++;
            $display("FAIL reset_res_data got=%h exp=0", res_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        mat_t a, b;
        bit   ok;
        a[0][0] = 1; a[0][1] = 2; a[1][0] = 3; a[1][1] = 4;
        b[0][0] = 5; b[0][1] = 6; b[1][0] = 7; b[1][1] = 8;
        load_job(a, b, 0, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_load got=timeout exp=accepted"); end
        wait_feed(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_feed got=timeout exp=feed"); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if ({arr_rst_n, arr_valid_in, busy, ld_ready} !== 4'b1110) begin
                failures++;
                $display("FAIL basic_feed_ctrl k=%0d got=%b exp=1110", k,
                         {arr_rst_n, arr_valid_in, busy, ld_ready});
            end
            checks++;
            if (arr_a !== col_of(a, k) || arr_b !== b[k]) begin
                failures++;
                $display("FAIL basic_feed_data k=%0d got=%h/%h exp=%h/%h", k, arr_a, arr_b,
                         col_of(a, k), b[k]);
            end
            @(negedge clk);
        end
        checks++;
        if (arr_valid_in !== 1'b0 || arr_a !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_collect got=%b/%h/%b exp=0/0/1", arr_valid_in, arr_a, busy);
        end
        tick();
        get_rows(N, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_rows got=%0d exp=%0d", got_data.size(), N); end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a, b, r) || got_last[r] !== (r == N - 1)) begin
                failures++;
                $display("FAIL basic_row%0d got=%h last=%b exp=%h last=%b", r, got_data[r],
                         got_last[r], model_row(a, b, r), (r == N - 1));
            end
        end
    endtask

    task automatic test_interleave();
        mat_t a, b;
        bit   ok, bok;
        a = rand_mat();
        b = rand_mat();
        ok = 1'b1;
        idle_gap(3); send_beat(1'b1, b[0], bok); ok = ok && bok;
        idle_gap(3); send_beat(1'b0, a[0], bok); ok = ok && bok;
        idle_gap(3); send_beat(1'b0, a[1], bok); ok = ok && bok;
        // Extra A beat while A is full: must stall, not overwrite.
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_data  = ~a[1];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ld_ready !== 1'b0) begin
                failures++;
                $display("FAIL interleave_stall c=%0d got=%b exp=0", c, ld_ready);
            end
            tick();
        end
        ld_valid = 1'b0;
        idle_gap(3); send_beat(1'b1, b[1], bok); ok = ok && bok;
        checks++;
        if (!ok) begin failures++; $display("FAIL interleave_load got=timeout exp=accepted"); end
        get_rows(N, 30, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL interleave_rows got=%0d exp=%0d", got_data.size(), N); end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a, b, r)) begin
                failures++;
                $display("FAIL interleave_row%0d got=%h exp=%h", r, got_data[r], model_row(a, b, r));
            end
        end
    endtask

    task automatic test_backpressure();
        mat_t a, b;
        bit   ok;
        a[0][0] = 1; a[0][1] = 2; a[1][0] = 3; a[1][1] = 4;
        b[0][0] = 5; b[0][1] = 6; b[1][0] = 7; b[1][1] = 8;
        res_ready = 1'b0;
        load_job(a, b, 1, 2, ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_valid got=timeout exp=res_valid"); end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (res_valid !== 1'b1 || res_last !== 1'b0 || res_data !== model_row(a, b, 0)) begin
                failures++;
                $display("FAIL bp_hold c=%0d got=%b/%b/%h exp=1/0/%h", c, res_valid, res_last,
                         res_data, model_row(a, b, 0));
            end
            @(negedge clk);
        end
        tick();
        get_rows(N, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_rows got=%0d exp=%0d", got_data.size(), N); end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a, b, r)) begin
                failures++;
                $display("FAIL bp_row%0d got=%h exp=%h", r, got_data[r], model_row(a, b, r));
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_back_to_back();
        mat_t a1, b1, a2, b2;
        bit   ok, seen;
        a1 = rand_mat();
        b1 = rand_mat();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a2[i][j] = (i == j) ? 16'd1 : 16'd0;
                b2[i][j] = 16'd9;
            end
        res_ready = 1'b0;
        load_job(a1, b1, 0, 0, ok);
        load_job(a2, b2, 1, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_load got=timeout exp=accepted"); end
        tick();
        got_data.delete();
        seen = 1'b0;
        res_ready = 1'b1;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got_data.push_back(res_data);
                if (res_last) begin
                    seen = 1'b1;
                    @(negedge clk);
                    checks++;
                    if (arr_valid_in !== 1'b1 || arr_rst_n !== 1'b1 || arr_a !== col_of(a2, 0)) begin
                        failures++;
                        $display("FAIL b2b_no_idle got=%b/%b/%h exp=1/1/%h", arr_valid_in,
                                 arr_rst_n, arr_a, col_of(a2, 0));
                    end
                end
            end
            tick();
        end
        checks++;
        if (got_data.size() != N) begin
            failures++;
            $display("FAIL b2b_job1_rows got=%0d exp=%0d", got_data.size(), N);
        end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a1, b1, r)) begin
                failures++;
                $display("FAIL b2b_job1_row%0d got=%h exp=%h", r, got_data[r], model_row(a1, b1, r));
            end
        end
        get_rows(N, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL b2b_job2_rows got=%0d exp=%0d", got_data.size(), N); end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a2, b2, r)) begin
                failures++;
                $display("FAIL b2b_job2_row%0d got=%h exp=%h", r, got_data[r], model_row(a2, b2, r));
            end
        end
    endtask

    task automatic test_wrap();
        mat_t a, b;
        bit   ok;
        a = '0;
        b = '0;
        a[0][0] = 16'hFFFF;
        b[0][0] = 16'hFFFF;
        load_job(a, b, 0, 1, ok);
        get_rows(N, 0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrap_rows got=%0d exp=%0d", got_data.size(), N); end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a, b, r)) begin
                failures++;
                $display("FAIL wrap_row%0d got=%h exp=%h", r, got_data[r], model_row(a, b, r));
            end
        end
    endtask

    task automatic test_reset_mid_feed();
        mat_t a, b;
        bit   ok;
        a = rand_mat();
        b = rand_mat();
        load_job(a, b, 0, 0, ok);
        wait_feed(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstfeed_feed got=timeout exp=feed"); end
        rst_n = 1'b0;
        #1;
        ld_sel = 1'b1;
        #1;
        checks++;
        if ({ld_ready, res_valid, res_last, busy, err, arr_rst_n, arr_valid_in} !== 7'b1000000) begin
            failures++;
            $display("FAIL rstfeed_ctrl got=%b exp=1000000",
                     {ld_ready, res_valid, res_last, busy, err, arr_rst_n, arr_valid_in});
        end
        checks++;
        if (arr_a !== '0 || arr_b !== '0 || res_data !== '0) begin
            failures++;
            $display("FAIL rstfeed_data got=%h/%h/%h exp=0/0/0", arr_a, arr_b, res_data);
        end
        ld_sel = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        a = rand_mat();
        b = rand_mat();
        load_job(a, b, 1, 2, ok);
        get_rows(N, 25, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstfeed_rows got=%0d exp=%0d", got_data.size(), N); end
        for (int r = 0; r < got_data.size(); r++) begin
            checks++;
            if (got_data[r] !== model_row(a, b, r)) begin
                failures++;
                $display("FAIL rstfeed_row%0d got=%h exp=%h", r, got_data[r], model_row(a, b, r));
            end
        end
    endtask

    task automatic test_random_jobs();
        mat_t a, b;
        bit   ok;
        for (int job = 0; job < 6; job++) begin
            a = rand_mat();
            b = rand_mat();
            load_job(a, b, int'($urandom_range(1)), 3, ok);
            get_rows(N, 40, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand%0d_rows got=%0d exp=%0d", job, got_data.size(), N);
            end
            for (int r = 0; r < got_data.size(); r++) begin
                checks++;
                if (got_data[r] !== model_row(a, b, r) || got_last[r] !== (r == N - 1)) begin
                    failures++;
                    $display("FAIL rand%0d_row%0d got=%h exp=%h", job, r, got_data[r],
                             model_row(a, b, r));
                end
            end
        end
    endtask

`ifdef SYS_JOB_CTRL_WDOG_EN
    task automatic test_wdog();
        mat_t a, b;
        bit   ok;
        int   cnt;
        a = rand_mat();
        b = rand_mat();
        block_out = 1'b1;
        load_job(a, b, 0, 0, ok);
        wait_feed(ok);
        repeat (N) @(negedge clk);
        cnt = 0;
        while (err === 1'b0 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 4 * N) begin failures++; $display("FAIL wdog_cycles got=%0d exp=%0d", cnt, 4 * N); end
        checks++;
        if ({busy, ld_ready, arr_rst_n, res_valid} !== 4'b0100) begin
            failures++;
            $display("FAIL wdog_load got=%b exp=0100", {busy, ld_ready, arr_rst_n, res_valid});
        end
        block_out = 1'b0;
        tick();
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", err); end
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_interleave();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid_feed();
        test_random_jobs();
`ifdef SYS_JOB_CTRL_WDOG_EN
        test_wdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
